// File: rtl/pcie_tx_commit_pkg.sv
// Shared types, header field positions and helpers for the TX A/B commit arbiter.
package pcie_tx_commit_pkg;
    localparam int TAG_W = 10;
    localparam int HDR_W = 256;

    localparam logic [7:0] FMT_MWR32 = 8'h40;
    localparam logic [7:0] FMT_MWR64 = 8'h60;
    localparam logic [7:0] FMT_CPL   = 8'h0A;

    // DW0: fmt_type/tag_h/tag_m/length, DW1: request tag_l, DW2: completion tag_l,
    // DW5: pf_num/vf_active/vf_num.
    localparam int FMT_LSB       = 24;
    localparam int TAG_H_BIT     = 23;
    localparam int TAG_M_BIT     = 19;
    localparam int REQ_TAG_L_LSB = 40;
    localparam int CPL_TAG_L_LSB = 72;
    localparam int PF_LSB        = 160;
    localparam int VF_ACT_BIT    = 173;
    localparam int VF_LSB        = 174;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_A = 2'd1,
        ARB_GRANT_B = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2:0]       pf_num;
        logic [10:0]      vf_num;
        logic             vf_active;
    } commit_entry_t;

    localparam int COMMIT_W = $bits(commit_entry_t);

    function automatic logic is_write(input logic [HDR_W-1:0] hdr);
        return (hdr[FMT_LSB +: 8] == FMT_MWR32) || (hdr[FMT_LSB +: 8] == FMT_MWR64);
    endfunction

    function automatic commit_entry_t parse_req_hdr(input logic [HDR_W-1:0] hdr);
        commit_entry_t e;
        e.tag       = {hdr[TAG_H_BIT], hdr[TAG_M_BIT], hdr[REQ_TAG_L_LSB +: 8]};
        e.pf_num    = hdr[PF_LSB +: 3];
        e.vf_num    = hdr[VF_LSB +: 11];
        e.vf_active = hdr[VF_ACT_BIT];
        return e;
    endfunction

    function automatic logic [HDR_W-1:0] build_commit_hdr(input commit_entry_t e);
        logic [HDR_W-1:0] hdr;
        hdr                       = '0;
        hdr[FMT_LSB +: 8]         = FMT_CPL;
        hdr[TAG_H_BIT]            = e.tag[9];
        hdr[TAG_M_BIT]            = e.tag[8];
        hdr[CPL_TAG_L_LSB +: 8]   = e.tag[7:0];
        hdr[PF_LSB +: 3]          = e.pf_num;
        hdr[VF_ACT_BIT]           = e.vf_active;
        hdr[VF_LSB +: 11]         = e.vf_num;
        return hdr;
    endfunction
endpackage

// File: rtl/pcie_commit_fifo.sv
// Sync FIFO of packed commit entries; output comes straight from flops.
module pcie_commit_fifo
    import pcie_tx_commit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [COMMIT_W-1:0]     push_data_i,
    input  logic                    pop_i,
    output logic [COMMIT_W-1:0]     pop_data_o,
    output logic                    valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    almost_full_o,
    output logic                    drop_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [COMMIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                drop_q;
    logic                full, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full || do_pop);
    assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (push_i && !do_push) drop_q <= 1'b1;
        end
    end

    assign pop_data_o    = mem_q[rd_ptr_q];
    assign valid_o       = (count_q != '0);
    assign count_o       = count_q;
    assign almost_full_o = (count_q > CNT_W'(DEPTH - 2));
    assign drop_o        = drop_q;
endmodule

// File: rtl/pcie_tx_ab_commit_arb.sv
// Merges a port's AFU TX A/B streams into one PCIe TX stream and returns a
// local commit Cpl on RX B for every write whose tlast wins on A.
module pcie_tx_ab_commit_arb
    import pcie_tx_commit_pkg::*;
#(
    parameter int TDATA_W      = 512,
    parameter int TUSER_W      = 10,
    parameter int COMMIT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  tx_a_tvalid_i,
    output logic                  tx_a_tready_o,
    input  logic [TDATA_W-1:0]    tx_a_tdata_i,
    input  logic [TDATA_W/8-1:0]  tx_a_tkeep_i,
    input  logic                  tx_a_tlast_i,
    input  logic [TUSER_W-1:0]    tx_a_tuser_i,

    input  logic                  tx_b_tvalid_i,
    output logic                  tx_b_tready_o,
    input  logic [TDATA_W-1:0]    tx_b_tdata_i,
    input  logic [TDATA_W/8-1:0]  tx_b_tkeep_i,
    input  logic                  tx_b_tlast_i,
    input  logic [TUSER_W-1:0]    tx_b_tuser_i,

    output logic                  tx_out_tvalid_o,
    input  logic                  tx_out_tready_i,
    output logic [TDATA_W-1:0]    tx_out_tdata_o,
    output logic [TDATA_W/8-1:0]  tx_out_tkeep_o,
    output logic                  tx_out_tlast_o,
    output logic [TUSER_W-1:0]    tx_out_tuser_o,

    output logic                  rx_b_tvalid_o,
    input  logic                  rx_b_tready_i,
    output logic [TDATA_W-1:0]    rx_b_tdata_o,
    output logic [TDATA_W/8-1:0]  rx_b_tkeep_o,
    output logic                  rx_b_tlast_o,
    output logic [TUSER_W-1:0]    rx_b_tuser_o,

    output logic                  commit_drop
);
    localparam int KEEP_W = TDATA_W / 8;

    arb_state_e    state_q;
    logic          last_a_q;
    logic          a_sop_q;
    logic          hdr_wr_q;
    commit_entry_t hdr_q;

    logic          a_elig, sel_a, sel_b, a_acc, b_acc;
    logic          sop_wr, push_wr, push;
    commit_entry_t sop_entry, push_entry, pop_entry;
    logic [COMMIT_W-1:0]           pop_data;
    logic                          fifo_valid, fifo_afull;
    logic [$clog2(COMMIT_DEPTH):0] fifo_count;

    // A needs room for its eventual commit before it may start a packet.
    assign a_elig = tx_a_tvalid_i && !fifo_afull;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (a_elig && tx_b_tvalid_i) begin
                    sel_a = !last_a_q;
                    sel_b = last_a_q;
                end else if (a_elig) begin
                    sel_a = 1'b1;
                end else if (tx_b_tvalid_i) begin
                    sel_b = 1'b1;
                end
            end
            ARB_GRANT_A: sel_a = 1'b1;
            ARB_GRANT_B: sel_b = 1'b1;
            default: ;
        endcase
    end

    assign a_acc         = sel_a && tx_a_tvalid_i && tx_out_tready_i;
    assign b_acc         = sel_b && tx_b_tvalid_i && tx_out_tready_i;
    assign tx_a_tready_o = sel_a && tx_out_tready_i;
    assign tx_b_tready_o = sel_b && tx_out_tready_i;

    always_comb begin
        tx_out_tvalid_o = 1'b0;
        tx_out_tdata_o  = '0;
        tx_out_tkeep_o  = '0;
        tx_out_tlast_o  = 1'b0;
        tx_out_tuser_o  = '0;
        if (sel_a) begin
            tx_out_tvalid_o = tx_a_tvalid_i;
            tx_out_tdata_o  = tx_a_tdata_i;
            tx_out_tkeep_o  = tx_a_tkeep_i;
            tx_out_tlast_o  = tx_a_tlast_i;
            tx_out_tuser_o  = tx_a_tuser_i;
        end else if (sel_b) begin
            tx_out_tvalid_o = tx_b_tvalid_i;
            tx_out_tdata_o  = tx_b_tdata_i;
            tx_out_tkeep_o  = tx_b_tkeep_i;
            tx_out_tlast_o  = tx_b_tlast_i;
            tx_out_tuser_o  = tx_b_tuser_i;
        end
    end

    // Single-beat packets commit from the live SOP header, longer ones from the latch.
    assign sop_entry  = parse_req_hdr(tx_a_tdata_i[HDR_W-1:0]);
    assign sop_wr     = is_write(tx_a_tdata_i[HDR_W-1:0]);
    assign push_entry = a_sop_q ? sop_entry : hdr_q;
    assign push_wr    = a_sop_q ? sop_wr : hdr_wr_q;
    assign push       = a_acc && tx_a_tlast_i && push_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            last_a_q <= 1'b0;
            a_sop_q  <= 1'b1;
            hdr_wr_q <= 1'b0;
            hdr_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (sel_a) begin
                        if (a_acc && tx_a_tlast_i) last_a_q <= 1'b1;
                        else                       state_q  <= ARB_GRANT_A;
                    end else if (sel_b) begin
                        if (b_acc && tx_b_tlast_i) last_a_q <= 1'b0;
                        else                       state_q  <= ARB_GRANT_B;
                    end
                end
                ARB_GRANT_A: begin
                    if (a_acc && tx_a_tlast_i) begin
                        state_q  <= ARB_IDLE;
                        last_a_q <= 1'b1;
                    end
                end
                ARB_GRANT_B: begin
                    if (b_acc && tx_b_tlast_i) begin
                        state_q  <= ARB_IDLE;
                        last_a_q <= 1'b0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase

            if (a_acc) begin
                a_sop_q <= tx_a_tlast_i;
                if (a_sop_q) begin
                    hdr_q    <= sop_entry;
                    hdr_wr_q <= sop_wr;
                end
            end
        end
    end

    pcie_commit_fifo #(
        .DEPTH (COMMIT_DEPTH)
    ) u_commit_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_data_i   (push_entry),
        .pop_i         (rx_b_tready_i),
        .pop_data_o    (pop_data),
        .valid_o       (fifo_valid),
        .count_o       (fifo_count),
        .almost_full_o (fifo_afull),
        .drop_o        (commit_drop)
    );

    assign pop_entry     = commit_entry_t'(pop_data);
    assign rx_b_tvalid_o = fifo_valid;
    assign rx_b_tdata_o  = TDATA_W'(build_commit_hdr(pop_entry));
    assign rx_b_tkeep_o  = KEEP_W'({32{1'b1}});
    assign rx_b_tlast_o  = 1'b1;
    assign rx_b_tuser_o  = '0;

    logic unused_count;
    assign unused_count = ^fifo_count;
endmodule

// File: tb/tb_pcie_tx_ab_commit_arb.sv
// Directed bench for the TX A/B commit arbiter: arbitration, commit generation, back-pressure, reset.
module tb_pcie_tx_ab_commit_arb;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, a_last, b_valid, b_last;
    logic [511:0] a_data, b_data;
    logic [9:0]   a_user, b_user;
    logic         a_ready, b_ready;
    logic         out_valid, out_ready, out_last;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic [9:0]   out_user;
    logic         rx_valid, rx_ready, rx_last;
    logic [511:0] rx_data;
    logic [63:0]  rx_keep;
    logic [9:0]   rx_user;
    logic         drop;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcie_tx_ab_commit_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_a_tvalid_i   (a_valid),
        .tx_a_tready_o   (a_ready),
        .tx_a_tdata_i    (a_data),
        .tx_a_tkeep_i    ({64{1'b1}}),
        .tx_a_tlast_i    (a_last),
        .tx_a_tuser_i    (a_user),
        .tx_b_tvalid_i   (b_valid),
        .tx_b_tready_o   (b_ready),
        .tx_b_tdata_i    (b_data),
        .tx_b_tkeep_i    ({64{1'b1}}),
        .tx_b_tlast_i    (b_last),
        .tx_b_tuser_i    (b_user),
        .tx_out_tvalid_o (out_valid),
        .tx_out_tready_i (out_ready),
        .tx_out_tdata_o  (out_data),
        .tx_out_tkeep_o  (out_keep),
        .tx_out_tlast_o  (out_last),
        .tx_out_tuser_o  (out_user),
        .rx_b_tvalid_o   (rx_valid),
        .rx_b_tready_i   (rx_ready),
        .rx_b_tdata_o    (rx_data),
        .rx_b_tkeep_o    (rx_keep),
        .rx_b_tlast_o    (rx_last),
        .rx_b_tuser_o    (rx_user),
        .commit_drop     (drop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] req_hdr(input logic [7:0] fmt, input logic [9:0] tag);
        logic [255:0] h;
        h          = '0;
        h[31:24]   = fmt;
        h[23]      = tag[9];
        h[19]      = tag[8];
        h[9:0]     = 10'd2;
        h[47:40]   = tag[7:0];
        h[127:64]  = 64'h0000_0012_3456_7800;
        h[162:160] = 3'd2;
        h[173]     = 1'b1;
        h[184:174] = 11'h5A5;
        return h;
    endfunction

    function automatic logic [511:0] exp_cpl(input logic [9:0] tag);
        logic [511:0] h;
        h          = '0;
        h[31:24]   = 8'h0A;
        h[23]      = tag[9];
        h[19]      = tag[8];
        h[79:72]   = tag[7:0];
        h[162:160] = 3'd2;
        h[173]     = 1'b1;
        h[184:174] = 11'h5A5;
        return h;
    endfunction

    function automatic logic [511:0] adata(input logic [255:0] hdr);
        return {32'hA000_0000, 224'h0, hdr};
    endfunction

    function automatic logic [511:0] bdata(input int bi);
        logic [511:0] d;
        d          = '0;
        d[511:480] = 32'hB000_0000 + 32'(bi);
        if (bi == 0) d[255:0] = req_hdr(8'h30, 10'h0B0);
        return d;
    endfunction

    task automatic set_a(input logic v, input logic [511:0] d, input logic l, input logic [9:0] u);
        a_valid = v; a_data = d; a_last = l; a_user = u;
    endtask

    task automatic set_b(input logic v, input logic [511:0] d, input logic l);
        b_valid = v; b_data = d; b_last = l; b_user = 10'h0;
    endtask

    task automatic chk_cpl(input string t, input logic [9:0] tag);
        chk({t, "_cpl_valid"}, rx_valid, 1'b1);
        chk({t, "_cpl_tag"}, {rx_data[23], rx_data[19], rx_data[79:72]}, tag);
        chk({t, "_cpl_hdr"}, rx_data == exp_cpl(tag), 1'b1);
        chk({t, "_cpl_keep"}, rx_keep, 64'h0000_0000_FFFF_FFFF);
        chk({t, "_cpl_last"}, {rx_last, rx_user}, {1'b1, 10'h0});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_a(0, '0, 0, '0);
        set_b(0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, bi, cyc;
        rst_n = 1'b0;
        set_a(0, '0, 0, '0);
        set_b(0, '0, 0);
        out_ready = 1'b1;
        rx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_readys", {a_ready, b_ready}, 2'b00);
        chk("rst_drop", drop, 1'b0);

        // 1: two-beat MWr64, commit one cycle after tlast
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h60, 10'h155)), 0, 10'h3C);
        #1;
        chk("t1_b0_valid", out_valid, 1'b1);
        chk("t1_b0_fmt", out_data[31:24], 8'h60);
        chk("t1_b0_ready", a_ready, 1'b1);
        chk("t1_b0_keep_user", {out_keep[63:0] == {64{1'b1}}, out_user}, {1'b1, 10'h3C});
        @(negedge clk);
        set_a(1, {16{32'h1111_0001}}, 1, 10'h0);
        #1;
        chk("t1_b1_data", out_data[63:0], {2{32'h1111_0001}});
        chk("t1_b1_last", out_last, 1'b1);
        chk("t1_no_early_cpl", rx_valid, 1'b0);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        #1;
        chk_cpl("t1", 10'h155);
        @(negedge clk);
        #1;
        chk("t1_cpl_once", rx_valid, 1'b0);

        // 2: tie alternation after reset, A first
        do_reset();
        set_a(1, adata(req_hdr(8'h40, 10'h0AA)), 1, '0);
        set_b(1, {32'hB000_0000, 224'h0, req_hdr(8'h20, 10'h011)}, 1);
        #1;
        chk("t2_tie1_a", {a_ready, b_ready}, 2'b10);
        chk("t2_tie1_fmt", out_data[31:24], 8'h40);
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h20, 10'h012)), 1, '0);
        #1;
        chk("t2_tie2_b", {a_ready, b_ready}, 2'b01);
        chk("t2_tie2_tag", out_data[47:40], 8'h11);
        chk_cpl("t2", 10'h0AA);
        @(negedge clk);
        set_b(1, {32'hB000_0000, 224'h0, req_hdr(8'h20, 10'h013)}, 1);
        #1;
        chk("t2_tie3_a", {a_ready, b_ready}, 2'b10);
        chk("t2_tie3_tag", out_data[47:40], 8'h12);
        chk("t2_one_commit_a", rx_valid, 1'b0);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        set_b(0, '0, 0);
        #1;
        chk("t2_one_commit_b", rx_valid, 1'b0);
        chk("t2_idle", out_valid, 1'b0);

        // 3: commit back-pressure stalls A at 15 outstanding
        rx_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            set_a(1, adata(req_hdr(8'h40, 10'h100 + 10'(acc))), 1, '0);
            #1;
            if (a_ready) acc++;
        end
        chk("t3_accepted", 64'(acc), 64'd15);
        chk("t3_a_stalled", a_ready, 1'b0);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        rx_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            #1;
            chk("t3_drain_valid", rx_valid, 1'b1);
            chk("t3_drain_tag", {rx_data[23], rx_data[19], rx_data[79:72]}, 10'h100 + 10'(j));
            @(negedge clk);
        end
        #1;
        chk("t3_drained", rx_valid, 1'b0);
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h40, 10'h3A5)), 1, '0);
        #1;
        chk("t3_a_resumes", a_ready, 1'b1);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        #1;
        chk_cpl("t3", 10'h3A5);
        chk("t3_no_drop", drop, 1'b0);

        // 4: B 4-beat packet under random tx_out back-pressure, A waiting
        bi  = 0;
        cyc = 0;
        while (bi < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            set_b(1, bdata(bi), bi == 3);
            if (cyc == 1) set_a(1, adata(req_hdr(8'h60, 10'h2F0)), 1, '0);
            #1;
            chk("t4_b_beat", out_data[511:480], 32'hB000_0000 + 32'(bi));
            chk("t4_a_held", a_ready, 1'b0);
            chk("t4_no_commit", rx_valid, 1'b0);
            if (out_ready) bi++;
            cyc++;
        end
        chk("t4_b_done", 64'(bi), 64'd4);
        @(negedge clk);
        out_ready = 1'b1;
        set_b(0, '0, 0);
        #1;
        chk("t4_a_after_b", {a_ready, out_data[511:480]}, {1'b1, 32'hA000_0000});
        @(negedge clk);
        set_a(0, '0, 0, '0);
        #1;
        chk_cpl("t4", 10'h2F0);

        // 5: non-write A traffic forwards without commits; DM-mode write still commits
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h20, 10'h044)), 1, '0);
        #1;
        chk("t5_mrd_fwd", {out_valid, out_data[31:24]}, {1'b1, 8'h20});
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h4A, 10'h045)), 0, '0);
        #1;
        chk("t5_cpl_fwd", {out_valid, out_data[31:24]}, {1'b1, 8'h4A});
        @(negedge clk);
        set_a(1, {16{32'h4545_4545}}, 1, '0);
        #1;
        chk("t5_mrd_no_commit", rx_valid, 1'b0);
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h40, 10'h046)), 1, 10'h001);
        #1;
        chk("t5_cpl_no_commit", rx_valid, 1'b0);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        #1;
        chk_cpl("t5_dm", 10'h046);

        // 6: reset during beat 2 of a 4-beat write abandons it
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h60, 10'h2C3)), 0, '0);
        #1;
        chk("t6_b0_ready", a_ready, 1'b1);
        @(negedge clk);
        set_a(1, {16{32'h6666_0001}}, 0, '0);
        @(negedge clk);
        set_a(1, {16{32'h6666_0002}}, 0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_a(0, '0, 0, '0);
        #1;
        chk("t6_rst_valids", {out_valid, rx_valid, a_ready}, 3'b000);
        @(negedge clk);
        #1;
        chk("t6_no_commit", rx_valid, 1'b0);
        @(negedge clk);
        set_a(1, adata(req_hdr(8'h40, 10'h3FF)), 1, '0);
        #1;
        chk("t6_new_ready", a_ready, 1'b1);
        @(negedge clk);
        set_a(0, '0, 0, '0);
        #1;
        chk_cpl("t6", 10'h3FF);
        @(negedge clk);
        #1;
        chk("t6_single_commit", rx_valid, 1'b0);
        chk("end_no_drop", drop, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
